// File: rtl/five_fetch_exec_if.sv
// Instruction/data memory and status bundle between the fetch/exec core and its environment.
// The core takes the master side; memories and observers take the slave side.
interface five_fetch_exec_if;
    logic [11:0] addr;
    logic [15:0] ins;
    logic [11:0] daddr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        dwe;
    logic [15:0] acc;
    logic        halt;
    logic        err;
    logic [15:0] retired;

    modport master (
        output addr, daddr, dout, dwe, acc, halt, err, retired,
        input  ins, din
    );

    modport slave (
        input  addr, daddr, dout, dwe, acc, halt, err, retired,
        output ins, din
    );
endinterface

// File: rtl/five_fetch_exec.sv
// Two-cycle accumulator machine: FETCH latches the instruction, EXEC applies it.
// Halts on STOP or on an illegal opcode; only rst leaves HALT.
module five_fetch_exec #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input logic                  clk,
    input logic                  rst,
    five_fetch_exec_if.master    bus
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

    state_e      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] ret_q, ret_d;
    logic        err_q, err_d;
    logic        dwe;
    logic [3:0]  op;

    assign op = ir_q[15:12];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        ret_d   = ret_q;
        err_d   = err_q;
        dwe     = 1'b0;
        unique case (state_q)
            StFetch: begin
                ir_d    = bus.ins;
                pc_d    = pc_q + 12'd1;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                // Opcodes 0-9 retire; the counter sticks at its maximum.
                if (op <= 4'h9 && ret_q != 16'hFFFF) begin
                    ret_d = ret_q + 16'd1;
                end
                case (op)
                    4'h0: acc_d = 16'h0000;
                    4'h1: acc_d = bus.din;
                    4'h2: acc_d = acc_q + bus.din;
                    4'h3: acc_d = ~acc_q;
                    4'h4: acc_d = {acc_q[15], acc_q[15:1]};
                    4'h5: acc_d = {acc_q[14:0], acc_q[15]};
                    4'h6: dwe = 1'b1;
                    4'h7: if (acc_q[15]) pc_d = ir_q[11:0];
                    4'h8: pc_d = ir_q[11:0];
                    4'h9: state_d = StHalt;
                    default: begin
                        state_d = StHalt;
                        err_d   = 1'b1;
                    end
                endcase
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
            acc_q   <= 16'h0000;
            ret_q   <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
        end
    end

    assign bus.addr    = pc_q;
    assign bus.daddr   = ir_q[11:0];
    assign bus.dout    = acc_q;
    // A reset edge must never see a pending store.
    assign bus.dwe     = dwe & ~rst;
    assign bus.acc     = acc_q;
    assign bus.halt    = (state_q == StHalt);
    assign bus.err     = err_q;
    assign bus.retired = ret_q;

endmodule

// File: doc/five_fetch_exec.md
FIVE_FETCH_EXEC -- requirements
Module: five_fetch_exec

Interface
REQ-001 Parameter RESET_PC, default 12'h000, the instruction address loaded into the PC at reset.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Addr  output  12  instruction address to the instruction memory, equal to the PC register.
REQ-005 Ins  input  16  instruction word returned combinationally for Addr; [15:12] opcode, [11:0] operand address.
REQ-006 DAddr  output  12  data memory address, equal to IR[11:0].
REQ-007 DIn  input  16  data word returned combinationally for DAddr.
REQ-008 DOut  output  16  write data to data memory, equal to ACC.
REQ-009 DWe  output  1  data memory write strobe, one cycle wide.
REQ-010 Acc  output  16  accumulator contents.
REQ-011 Halt  output  1  high while in the HALT state.
REQ-012 Err  output  1  high when halt was caused by an illegal opcode.
REQ-013 Retired  output  16  count of completed instructions.

Function
REQ-014 FSM states: FETCH, EXEC, HALT; each legal instruction takes 2 cycles (FETCH then EXEC).
REQ-015 FETCH: IR <= Ins, PC <= PC+1 modulo 2^12 (12'hFFF wraps to 12'h000); next state EXEC.
REQ-016 EXEC by IR[15:12]; next state FETCH unless stated otherwise:
- 0 CLA: ACC <= 0.
- 1 LDA: ACC <= DIn.
- 2 ADD: ACC <= ACC+DIn modulo 2^16, carry discarded.
- 3 COM: ACC <= ~ACC.
- 4 SHR: ACC <= {ACC[15], ACC[15:1]} (arithmetic).
- 5 CSL: ACC <= {ACC[14:0], ACC[15]} (rotate left).
- 6 STA: DWe=1 during this cycle only; memory captures DOut=ACC at DAddr; ACC unchanged.
- 7 BAN: if ACC[15]==1, PC <= IR[11:0]; otherwise PC unchanged.
- 8 JMP: PC <= IR[11:0] unconditionally.
- 9 STOP: next state HALT, Err=0.
- A-F illegal: no architectural change; next state HALT, Err=1.
REQ-017 Retired increments by 1 at the end of every EXEC of opcodes 0-9 (STOP included) and saturates at 16'hFFFF; illegal opcodes do not increment.
REQ-018 HALT: PC, IR, ACC, Retired frozen; DWe=0; Addr holds the address after the halting instruction; exited only by rst.
REQ-019 DWe SHALL be 0 in FETCH, in HALT, and in EXEC for every opcode other than 6.
REQ-020 A branch or jump to its own address (e.g. 12'h007 at 12'h007) loops indefinitely with no special handling.
REQ-021 Ins is sampled only in FETCH and DIn only in EXEC of opcodes 1 and 2; other changes on these inputs are ignored.

Reset
REQ-022 When rst=1 at a rising edge: PC=RESET_PC, IR=0, ACC=0, Retired=0, Err=0, state=FETCH; regardless of current state, including mid-EXEC and HALT.
REQ-023 During a reset cycle DWe SHALL be 0, and no pending STA write may occur.
REQ-024 After rst deasserts, the first FETCH occurs on the next rising edge and reads RESET_PC.

Verification
REQ-025 Program: CLA; LDA 2; ADD 3; STA 4; STOP, with data[2]=16'h0005, data[3]=16'h0007 -> data[4]=16'h000C, Acc=16'h000C, Halt=1 at cycle 10, Retired=5, Err=0.
REQ-026 ACC=16'h8001; COM -> 16'h7FFE; SHR on 16'h8001 -> 16'hC000; CSL on 16'h8001 -> 16'h0003.
REQ-027 BAN 12'h020 with ACC=16'h8000 -> next Addr=12'h020; with ACC=16'h7FFF -> next Addr is the following instruction; JMP 12'h003 -> Addr=12'h003.
REQ-028 Opcode 4'hB at address 12'h005 -> Halt=1, Err=1, Acc unchanged, Retired unchanged, Addr=12'h006 held.
REQ-029 PC=12'hFFF holding CLA -> next Addr=12'h000; ADD with 16'hFFFF+16'h0002 -> Acc=16'h0001.
REQ-030 rst asserted during the EXEC of STA -> DWe=0 that cycle, data memory unchanged, next Addr=RESET_PC, Acc=0.
